// File: rtl/dht_pkg.sv
// dht_pkg: FSM state encoding, DHT protocol constants and frame checksum helper
package dht_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START_LOW,
        WAIT_RESP,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        CHECK,
        COOLDOWN
    } state_t;

    localparam int RESP_US    = 80;
    localparam int FRAME_BITS = 40;

    // Frame is {hum_hi, hum_lo, temp_hi, temp_lo, checksum}, MSB first
    function automatic logic checksum_ok(input logic [39:0] f);
        logic [7:0] s;
        s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        return s == f[7:0];
    endfunction

endpackage

// File: rtl/usec_tick.sv
// usec_tick: one-cycle pulse every CLK_FREQ_HZ/1_000_000 clock cycles
module usec_tick #(
    parameter int CLK_FREQ_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset_p,
    output logic tick
);

    localparam int DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int W   = DIV > 1 ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;
    logic         wrap;

    assign wrap = cnt == W'(DIV - 1);

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= wrap ? '0 : cnt + 1'b1;
            tick <= wrap;
        end
    end

endmodule

// File: rtl/dht_sensor_ctrl.sv
// dht_sensor_ctrl: DHT11/DHT22 single-wire reader; start pulse, response handshake,
// 40-bit frame decode by high-time, checksum, timeouts and post-read cooldown
module dht_sensor_ctrl
    import dht_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = 100_000_000,
    parameter int START_LOW_US_11 = 18000,
    parameter int START_LOW_US_22 = 1000,
    parameter int BIT_THRESH_US   = 48,
    parameter int TIMEOUT_US      = 255,
    parameter int COOLDOWN_MS     = 1000,
    parameter int AUTO_PERIOD_MS  = 0
) (
    input  logic        clk,
    input  logic        reset_p,
    inout  wire         dht_data,
    input  logic        start,
    input  logic        mode_dht22,
    output logic        busy,
    output logic        data_valid,
    output logic        checksum_err,
    output logic        timeout_err,
    output logic [15:0] humidity,
    output logic [15:0] temperature
);

    localparam logic [31:0] S11_US  = 32'(START_LOW_US_11);
    localparam logic [31:0] S22_US  = 32'(START_LOW_US_22);
    localparam logic [31:0] THR_US  = 32'(BIT_THRESH_US);
    localparam logic [31:0] TO_US   = 32'(TIMEOUT_US);
    localparam logic [31:0] CD_US   = 32'(COOLDOWN_MS * 1000);
    localparam logic [31:0] AUTO_US = 32'(AUTO_PERIOD_MS * 1000);

    state_t      state, state_next;
    logic        tick;
    logic [1:0]  sync;
    logic        data_d, fall, rise;
    logic [31:0] cnt, auto_cnt;
    logic [5:0]  nbits;
    logic [39:0] sr;
    logic        dht22, auto_pend, auto_hit;
    logic        accept, shift, good, bad, expired;

    usec_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
        .clk     (clk),
        .reset_p (reset_p),
        .tick    (tick)
    );

    // The bus is only ever pulled low by the host during the start pulse
    assign dht_data = (state == START_LOW) ? 1'b0 : 1'bz;
    assign busy     = state != IDLE;
    assign fall     = data_d & ~sync[1];
    assign rise     = ~data_d & sync[1];
    assign auto_hit = (AUTO_US != 0) && tick && (auto_cnt >= AUTO_US - 32'd1);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        shift      = 1'b0;
        good       = 1'b0;
        bad        = 1'b0;
        expired    = 1'b0;
        unique case (state)
            IDLE:      if (start || auto_pend) begin
                           state_next = START_LOW;
                           accept     = 1'b1;
                       end
            START_LOW: if (cnt >= (dht22 ? S22_US : S11_US)) state_next = WAIT_RESP;
            WAIT_RESP: if (fall) state_next = RESP_LOW;
            RESP_LOW:  if (rise) state_next = RESP_HIGH;
            RESP_HIGH: if (fall) state_next = BIT_LOW;
            BIT_LOW:   if (rise) state_next = BIT_HIGH;
            BIT_HIGH:  if (fall) begin
                           shift      = 1'b1;
                           state_next = (nbits == 6'(FRAME_BITS - 1)) ? CHECK : BIT_LOW;
                       end
            CHECK:     begin
                           good       = checksum_ok(sr);
                           bad        = ~good;
                           state_next = COOLDOWN;
                       end
            COOLDOWN:  if (cnt >= CD_US) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        // A stalled sensor phase overrides any edge seen in the same cycle
        if (state inside {WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH} && tick && cnt >= TO_US) begin
            expired    = 1'b1;
            shift      = 1'b0;
            state_next = COOLDOWN;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            sync   <= 2'b11;
            data_d <= 1'b1;
        end else begin
            sync   <= {sync[0], dht_data};
            data_d <= sync[1];
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state        <= IDLE;
            cnt          <= '0;
            nbits        <= '0;
            sr           <= '0;
            dht22        <= 1'b0;
            auto_cnt     <= '0;
            auto_pend    <= 1'b0;
            data_valid   <= 1'b0;
            checksum_err <= 1'b0;
            timeout_err  <= 1'b0;
            humidity     <= '0;
            temperature  <= '0;
        end else begin
            state        <= state_next;
            cnt          <= (state_next != state) ? '0 : cnt + 32'(tick);
            auto_cnt     <= auto_hit ? '0 : auto_cnt + 32'(tick);
            auto_pend    <= (auto_pend | auto_hit) & ~accept;
            data_valid   <= good;
            checksum_err <= bad;
            timeout_err  <= expired;
            if (accept) begin
                dht22 <= mode_dht22;
                nbits <= '0;
                sr    <= '0;
            end
            if (shift) begin
                sr    <= {sr[38:0], cnt > THR_US};
                nbits <= nbits + 6'd1;
            end
            if (good) begin
                humidity    <= sr[39:24];
                temperature <= sr[23:8];
            end
        end
    end

endmodule

// File: tb/tb_dht_sensor_ctrl.sv
// tb_dht_sensor_ctrl: table-driven frame reads against a behavioural DHT sensor,
// plus timeout, cooldown-start and mid-frame reset sequences
module tb_dht_sensor_ctrl;
    localparam int S11 = 300;
    localparam int S22 = 100;
    localparam int TO  = 255;

    logic        clk = 1'b0;
    logic        reset_p, start, mode_dht22, sens_low;
    logic        busy, data_valid, checksum_err, timeout_err;
    logic [15:0] humidity, temperature;
    wire         dht_data;

    pullup (dht_data);
    assign dht_data = sens_low ? 1'b0 : 1'bz;

    dht_sensor_ctrl #(
        .CLK_FREQ_HZ(2_000_000), .START_LOW_US_11(S11), .START_LOW_US_22(S22),
        .BIT_THRESH_US(48), .TIMEOUT_US(TO), .COOLDOWN_MS(1), .AUTO_PERIOD_MS(0)
    ) dut (
        .clk(clk), .reset_p(reset_p), .dht_data(dht_data), .start(start),
        .mode_dht22(mode_dht22), .busy(busy), .data_valid(data_valid),
        .checksum_err(checksum_err), .timeout_err(timeout_err),
        .humidity(humidity), .temperature(temperature)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int errors = 0;
    int cyc = 0, n_dv = 0, n_ck = 0, n_to = 0, host_low = 0, rel_cyc = 0, to_cyc = 0;
    logic bus_prev = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) n_dv <= n_dv + 1;
        if (checksum_err) n_ck <= n_ck + 1;
        if (timeout_err) begin
            n_to   <= n_to + 1;
            to_cyc <= cyc;
        end
        if (dht_data === 1'b0 && !sens_low) host_low <= host_low + 1;
        if (!bus_prev && dht_data === 1'b1 && !sens_low) rel_cyc <= cyc;
        bus_prev <= dht_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        compared++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic us(input int n);
        repeat (2 * n) @(negedge clk);
    endtask

    task automatic wait_bus(input logic lvl, input int max_cyc, input string name);
        int n = 0;
        while (dht_data !== lvl && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(dht_data), 32'(lvl));
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic pulse_start(input logic m);
        mode_dht22 = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Behavioural sensor: answers the host start, then sends a frame; returns
    // halfway through the high phase of bit abort_bit when abort_bit >= 0
    task automatic sensor(input logic [39:0] f, input int zero_us, input int one_us, input int abort_bit);
        wait_bus(1'b0, 10, "host_start_low");
        wait_bus(1'b1, 2 * S11 + 20, "host_release");
        us(30);
        sens_low = 1'b1;
        us(dht_pkg::RESP_US);
        sens_low = 1'b0;
        us(dht_pkg::RESP_US);
        for (int i = 0; i < dht_pkg::FRAME_BITS; i++) begin
            sens_low = 1'b1;
            us(30);
            sens_low = 1'b0;
            if (i == abort_bit) begin
                us(one_us / 2);
                return;
            end
            us(f[39-i] ? one_us : zero_us);
        end
        sens_low = 1'b1;
        us(30);
        sens_low = 1'b0;
    endtask

    typedef struct {
        logic        mode;
        logic [39:0] frame;
        int          zero_us;
        int          one_us;
        logic        ok;
        logic [15:0] hum;
        logic [15:0] tmp;
        int          low_us;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int dv0, ck0, to0, hl0;
        vecs[0] = '{1'b0, {8'd80, 8'd0, 8'd25, 8'd0, 8'd105}, 27, 70, 1'b1, 16'h5000, 16'h1900, S11};
        vecs[1] = '{1'b0, {8'd80, 8'd0, 8'd25, 8'd0, 8'd106}, 27, 70, 1'b0, 16'h5000, 16'h1900, S11};
        vecs[2] = '{1'b1, 40'h028C015FEE, 27, 70, 1'b1, 16'h028C, 16'h015F, S22};
        vecs[3] = '{1'b1, 40'h028C015F00, 27, 70, 1'b0, 16'h028C, 16'h015F, S22};
        vecs[4] = '{1'b0, 40'h3701160957, 20, 60, 1'b1, 16'h3701, 16'h1609, S11};

        reset_p = 1'b1; start = 1'b0; mode_dht22 = 1'b0; sens_low = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_strobes", {29'd0, data_valid, checksum_err, timeout_err}, 0);
        chk("rst_hum", 32'(humidity), 0);
        chk("rst_temp", 32'(temperature), 0);
        chk("rst_bus", 32'(dht_data), 1);
        reset_p = 1'b0;
        us(5);

        for (int v = 0; v < 5; v++) begin
            dv0 = n_dv; ck0 = n_ck; to0 = n_to; hl0 = host_low;
            pulse_start(vecs[v].mode);
            chk($sformatf("v%0d_busy_start", v), 32'(busy), 1);
            sensor(vecs[v].frame, vecs[v].zero_us, vecs[v].one_us, -1);
            us(100);
            chk($sformatf("v%0d_busy_cooldown", v), 32'(busy), 1);
            wait_idle(3000, $sformatf("v%0d_idle", v));
            chk($sformatf("v%0d_dv", v), 32'(n_dv - dv0), vecs[v].ok ? 1 : 0);
            chk($sformatf("v%0d_ck", v), 32'(n_ck - ck0), vecs[v].ok ? 0 : 1);
            chk($sformatf("v%0d_to", v), 32'(n_to - to0), 0);
            chk($sformatf("v%0d_hum", v), 32'(humidity), 32'(vecs[v].hum));
            chk($sformatf("v%0d_temp", v), 32'(temperature), 32'(vecs[v].tmp));
            chk_range($sformatf("v%0d_start_low_cycles", v), host_low - hl0,
                      2 * vecs[v].low_us - 2, 2 * vecs[v].low_us + 3);
        end

        // Silent sensor: timeout measured from bus release
        dv0 = n_dv; ck0 = n_ck; to0 = n_to;
        pulse_start(1'b0);
        wait_idle(4000, "to_idle");
        chk("to_count", 32'(n_to - to0), 1);
        chk("to_no_other", 32'((n_dv - dv0) + (n_ck - ck0)), 0);
        chk_range("to_latency_cycles", to_cyc - rel_cyc, 2 * (TO - 1), 2 * (TO + 2));
        chk("to_bus", 32'(dht_data), 1);
        chk("to_hum_kept", 32'(humidity), 32'h3701);

        // Start during cooldown must be ignored
        dv0 = n_dv; hl0 = host_low;
        pulse_start(1'b0);
        sensor(vecs[0].frame, 27, 70, -1);
        us(100);
        pulse_start(1'b1);
        wait_idle(3000, "cd_idle");
        us(20);
        chk("cd_start_ignored", 32'(busy), 0);
        chk("cd_one_frame", 32'(n_dv - dv0), 1);
        chk_range("cd_one_start_low", host_low - hl0, 2 * S11 - 2, 2 * S11 + 3);

        // Reset during bit 20
        dv0 = n_dv; ck0 = n_ck; to0 = n_to;
        pulse_start(1'b0);
        sensor(vecs[4].frame, 27, 70, 20);
        #2 reset_p = 1'b1;
        #1;
        chk("rb_bus", 32'(dht_data), 1);
        chk("rb_busy", 32'(busy), 0);
        chk("rb_hum", 32'(humidity), 0);
        chk("rb_temp", 32'(temperature), 0);
        repeat (3) @(negedge clk);
        reset_p = 1'b0;
        us(400);
        chk("rb_no_strobes", 32'((n_dv - dv0) + (n_ck - ck0) + (n_to - to0)), 0);
        chk("rb_still_idle", 32'(busy), 0);

        // Reset while the host is driving the start pulse releases the bus at once
        pulse_start(1'b0);
        us(50);
        chk("rs_host_drive", 32'(dht_data), 0);
        #2 reset_p = 1'b1;
        #1;
        chk("rs_bus_released", 32'(dht_data), 1);
        chk("rs_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        reset_p = 1'b0;
        us(10);
        chk("rs_bus_after", 32'(dht_data), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end

endmodule

// File: doc/dht_sensor_ctrl.md
DHT_SENSOR_CTRL -- requirements
Module: dht_sensor_ctrl

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency; SHALL derive the 1 us tick.
REQ-002 Parameter START_LOW_US_11, default 18000, host start-low time in DHT11 mode.
REQ-003 Parameter START_LOW_US_22, default 1000, host start-low time in DHT22 mode.
REQ-004 Parameter BIT_THRESH_US, default 48, data-high duration above which a bit decodes as 1.
REQ-005 Parameter TIMEOUT_US, default 255, maximum duration of any sensor-driven phase.
REQ-006 Parameter COOLDOWN_MS, default 1000, minimum interval from end of a read to the next start; 0 disables.
REQ-007 Parameter AUTO_PERIOD_MS, default 0, periodic self-start interval; 0 disables.
REQ-008 Port clk  input  1  system clock; single clock domain.
REQ-009 Port reset_p  input  1  asynchronous, active-high reset.
REQ-010 Port dht_data  inout  1  open-drain single-wire bus, externally pulled up; driven only as 0, otherwise Z.
REQ-011 Port start  input  1  one-cycle read request.
REQ-012 Port mode_dht22  input  1  0 = DHT11 timing, 1 = DHT22 timing; sampled on accepted start.
REQ-013 Port busy  output  1  high from accepted start through end of cooldown.
REQ-014 Port data_valid  output  1  one-cycle strobe on good frame.
REQ-015 Port checksum_err  output  1  one-cycle strobe on checksum mismatch.
REQ-016 Port timeout_err  output  1  one-cycle strobe on any phase timeout.
REQ-017 Port humidity  output  16  {byte4, byte3} of last good frame (raw, MSB first).
REQ-018 Port temperature  output  16  {byte2, byte1} of last good frame (raw).

Function
REQ-019 dht_data SHALL pass a 2-flop synchronizer; all decoding uses the synchronized value and its edges.
REQ-020 A 1 us tick sub-module SHALL pulse once every CLK_FREQ_HZ/1_000_000 cycles; all phase counters count ticks and clear on every state change.
REQ-021 FSM states: IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, COOLDOWN.
REQ-022 IDLE -> START_LOW on start (or AUTO_PERIOD_MS expiry when nonzero); start while busy SHALL be ignored.
REQ-023 START_LOW drives dht_data 0 for the selected START_LOW_US, then releases (Z) -> WAIT_RESP.
REQ-024 WAIT_RESP -> RESP_LOW on falling edge; RESP_LOW -> RESP_HIGH on rising edge; RESP_HIGH -> BIT_LOW on falling edge.
REQ-025 BIT_LOW -> BIT_HIGH on rising edge; BIT_HIGH on falling edge shifts in (count > BIT_THRESH_US) and -> BIT_LOW, or -> CHECK after the 40th bit.
REQ-026 Any state in WAIT_RESP..BIT_HIGH exceeding TIMEOUT_US SHALL pulse timeout_err, release the bus, -> COOLDOWN.
REQ-027 CHECK: if (byte4+byte3+byte2+byte1) mod 256 == byte0, update humidity/temperature and pulse data_valid; else pulse checksum_err, outputs unchanged; -> COOLDOWN.
REQ-028 COOLDOWN lasts COOLDOWN_MS then -> IDLE; busy deasserts the cycle IDLE is entered.
REQ-029 Exactly one of data_valid/checksum_err/timeout_err SHALL pulse per accepted start.
REQ-030 The bus SHALL never be driven outside START_LOW.

Reset
REQ-031 reset_p SHALL asynchronously force IDLE, bus Z, busy/strobes 0, humidity/temperature 0, shift register and counters 0, even mid-frame.
REQ-032 AUTO_PERIOD_MS counter restarts from 0 on reset release.

Structure
REQ-033 State encoding and protocol constants (80 us response, 40-bit frame length) SHALL live in shared package dht_pkg.
REQ-034 Sub-module usec_tick (parameter CLK_FREQ_HZ) SHALL generate the 1 us tick.

Verification
REQ-035 DHT11, sensor model humidity 80, temperature 25, checksum 105, 0-bits 27 us, 1-bits 70 us -> data_valid, humidity 0x5000, temperature 0x1900.
REQ-036 Same frame with checksum 106 -> checksum_err, outputs keep prior values, busy held through cooldown.
REQ-037 Sensor never responds after release -> timeout_err at TIMEOUT_US+-1 us, bus Z.
REQ-038 mode_dht22=1, frame 0x02,0x8C,0x01,0x5F,0xEE -> start-low 1000 us, humidity 0x028C, temperature 0x015F.
REQ-039 reset_p asserted during bit 20 -> bus Z same cycle, outputs 0; start during COOLDOWN ignored.
